// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug dump engine.
//   - state_e      : dump controller FSM states
//   - REGION_*     : debug region codes carried in chk_addr[19:16]
//   - BYTE_ORDER_LE: serialisation order (1 = byte 0 / bits 7:0 first)
//   - NBYTES/IDX_W : bytes per serialised word and byte-index width
//   - pick_byte    : selects one byte of a serialiser word
// Optional build macro: DBG_DUMP_ADDR_HDR_EN (prefix each word with its
// 4-byte address, giving 8 bytes per word).
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LATCH,
    ST_SEND,
    ST_NEXT,
    ST_FIN
  } state_e;

  localparam logic [3:0] REGION_CPU_INFO = 4'h0;
  localparam logic [3:0] REGION_RF       = 4'h1;
  localparam logic [3:0] REGION_UPM      = 4'h2;
  localparam logic [3:0] REGION_IPM      = 4'h3;
  localparam logic [3:0] REGION_UDM      = 4'h4;
  localparam logic [3:0] REGION_USTACK   = 4'h5;

  localparam bit BYTE_ORDER_LE = 1'b1;

`ifdef DBG_DUMP_ADDR_HDR_EN
  localparam int NBYTES = 8;
  localparam int IDX_W  = 3;
`else
  localparam int NBYTES = 4;
  localparam int IDX_W  = 2;
`endif
  localparam int SER_W = NBYTES * 8;

  function automatic logic [7:0] pick_byte(input logic [SER_W-1:0] w,
                                           input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] sel;
    sel = BYTE_ORDER_LE ? idx : (IDX_W'(NBYTES - 1) - idx);
    return w[8*sel +: 8];
  endfunction

endpackage

// File: rtl/dbg_dump_ctrl_if.sv
// dbg_dump_ctrl_if: bundles the command, debug-mux and UART TX signals of the
// dump engine.
//   command : start, base_addr, word_cnt, abort -> engine; busy, done <- engine
//   debug   : chk_addr <- engine; chk_data -> engine (combinational mux reply)
//   uart tx : tx_data, tx_valid <- engine; tx_ready -> engine
// master = the dump engine, slave = its surroundings (decoder, mux, UART).
interface dbg_dump_ctrl_if #(parameter int CNT_W = 16);

  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_cnt;
  logic             abort;
  logic             busy;
  logic             done;
  logic [31:0]      chk_addr;
  logic [31:0]      chk_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    input  start, base_addr, word_cnt, abort, chk_data, tx_ready,
    output busy, done, chk_addr, tx_data, tx_valid
  );

  modport slave (
    output start, base_addr, word_cnt, abort, chk_data, tx_ready,
    input  busy, done, chk_addr, tx_data, tx_valid
  );

endinterface

// File: rtl/dbg_byte_ser.sv
// dbg_byte_ser: holds one word and emits it byte by byte over valid/ready.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : capture word_i and start emitting from byte 0
//   word_i       : word to serialise (SER_W bits)
//   stop_i       : end the word after the byte currently being transferred
//   tx_ready_i   : downstream ready
//   tx_data_o    : current byte (0 while idle)
//   tx_valid_o   : byte valid; only falls after a transfer (or on reset)
//   xfer_o       : a byte transfers this cycle
//   last_byte_o  : the presented byte is the final one of the word
// Width follows DBG_DUMP_ADDR_HDR_EN through dbg_pkg.
module dbg_byte_ser
  import dbg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [SER_W-1:0] word_i,
  input  logic             stop_i,
  input  logic             tx_ready_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             xfer_o,
  output logic             last_byte_o
);

  logic [SER_W-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;

  assign xfer_o      = vld_q & tx_ready_i;
  assign last_byte_o = (idx_q == IDX_W'(NBYTES - 1));
  assign tx_valid_o  = vld_q;
  assign tx_data_o   = vld_q ? pick_byte(word_q, idx_q) : 8'h00;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = '0;
      vld_d  = 1'b1;
    end else if (xfer_o) begin
      idx_d = idx_q + IDX_W'(1);
      if (last_byte_o || stop_i) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

  // Data holding register: never observed while vld_q is low, so no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: rtl/dbg_dump_ctrl.sv
// dbg_dump_ctrl: autonomous debug dump engine. Walks base_addr ..
// base_addr+word_cnt-1 on chk_addr, holds each address SETTLE_CYCLES cycles,
// latches chk_data and streams it little-endian to a UART TX.
// Ports: clk, rst (sync, active-high) plus interface bus (master modport):
//   start/base_addr/word_cnt/abort in, busy/done out,
//   chk_addr out / chk_data in, tx_data/tx_valid out / tx_ready in.
// Parameters: SETTLE_CYCLES (1..15), CNT_W (word-count width).
// Build macro DBG_DUMP_ADDR_HDR_EN: each word is preceded by its 4 address
// bytes (little-endian), captured together with the data in LATCH.
module dbg_dump_ctrl
  import dbg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
)
(
  input  logic       clk,
  input  logic       rst,
  dbg_dump_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       settle_q, settle_d;
  logic             abort_q, abort_d;

  logic             abort_now;
  logic             ser_load;
  logic             ser_xfer;
  logic             ser_last;
  logic [SER_W-1:0] ser_word;

  // abort is a level but may drop before the pending byte transfers, so it is
  // remembered for the rest of the dump.
  assign abort_now = bus.abort | abort_q;

`ifdef DBG_DUMP_ADDR_HDR_EN
  assign ser_word = {bus.chk_data, addr_q};
`else
  assign ser_word = bus.chk_data;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    settle_d = settle_q;
    abort_d  = 1'b0;
    ser_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // abort in the start cycle is ignored: abort_d stays low here.
        if (bus.start) begin
          addr_d   = bus.base_addr;
          cnt_d    = bus.word_cnt;
          settle_d = '0;
          state_d  = (bus.word_cnt == '0) ? ST_FIN : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        abort_d = abort_now;
        if (abort_now) begin
          state_d = ST_IDLE;
        end else if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          state_d = ST_LATCH;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_LATCH: begin
        abort_d = abort_now;
        if (abort_now) begin
          state_d = ST_IDLE;
        end else begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        abort_d = abort_now;
        if (ser_xfer) begin
          if (abort_now)     state_d = ST_IDLE;
          else if (ser_last) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        abort_d  = abort_now;
        cnt_d    = cnt_q - CNT_W'(1);
        settle_d = '0;
        // The final word leaves chk_addr on its own address.
        if (cnt_q != CNT_W'(1)) addr_d = addr_q + 32'd1;
        if (abort_now)                  state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1))    state_d = ST_FIN;
        else                            state_d = ST_SETTLE;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      settle_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      settle_q <= settle_d;
      abort_q  <= abort_d;
    end
  end

  assign bus.busy     = (state_q == ST_SETTLE) || (state_q == ST_LATCH) ||
                        (state_q == ST_SEND)   || (state_q == ST_NEXT);
  assign bus.done     = (state_q == ST_FIN);
  assign bus.chk_addr = addr_q;

  dbg_byte_ser u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .word_i      (ser_word),
    .stop_i      (abort_now),
    .tx_ready_i  (bus.tx_ready),
    .tx_data_o   (bus.tx_data),
    .tx_valid_o  (bus.tx_valid),
    .xfer_o      (ser_xfer),
    .last_byte_o (ser_last)
  );

endmodule

// File: tb/tb_dbg_dump_ctrl.sv
// tb_dbg_dump_ctrl: bench for dbg_dump_ctrl. Table of dump scenarios, hand
// sequences for abort and reset, then random dumps against a byte-stream
// model. Follows DBG_DUMP_ADDR_HDR_EN for the expected stream.
module tb_dbg_dump_ctrl;

  localparam int S     = 2;
  localparam int CW    = 16;
  localparam int LIMIT = 2000;
`ifdef DBG_DUMP_ADDR_HDR_EN
  localparam int NB = 8;
`else
  localparam int NB = 4;
`endif
  localparam int T = S + 2 + NB;  // cycles per word with tx_ready high

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbg_dump_ctrl_if #(.CNT_W(CW)) bus ();

  dbg_dump_ctrl #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Debug mux model: two fixed RF entries, otherwise constant or hashed.
  bit          const_mode;
  logic [31:0] const_val;

  function automatic logic [31:0] mux_data(input logic [31:0] a, input bit cm,
                                           input logic [31:0] cv);
    if (a == 32'h0001_0000) return 32'h0000_0000;
    if (a == 32'h0001_0001) return 32'h1234_5678;
    if (cm) return cv;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign bus.chk_data = mux_data(bus.chk_addr, const_mode, const_val);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor on the falling edge: records transfers, done pulses and stalls.
  logic [7:0] got_q[$];
  int   done_cnt   = 0;
  int   stab_viol  = 0;
  int   busy_viol  = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data))
        stab_viol <= stab_viol + 1;
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        if (bus.busy) busy_viol <= busy_viol + 1;
      end
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference stream: per word, optional address bytes then data bytes, LSB first.
  logic [7:0] exp_q[$];

  task automatic build_exp(input logic [31:0] base, input int cnt);
    exp_q.delete();
    for (int w = 0; w < cnt; w++) begin
      logic [31:0] a, d;
      a = base + 32'(w);
      d = mux_data(a, const_mode, const_val);
      if (NB == 8) for (int b = 0; b < 4; b++) exp_q.push_back(a[8*b +: 8]);
      for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
    end
  endtask

  task automatic cmp_bytes(input string tag, input int from);
    check($sformatf("%s_nbytes", tag), 64'(got_q.size() - from), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (from + i) < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[from+i]), 64'(exp_q[i]));
  endtask

  task automatic drive_ready(input int rmode, input int c);
    case (rmode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = (c % 2) == 1;
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Start a dump and run it to the return to idle. inj > 0 re-issues start
  // (base 0x0004_0000) in that cycle, which must be ignored.
  task automatic run_dump(input logic [31:0] base, input int cnt, input int rmode,
                          input int inj, output int first_cyc, output int done_cyc);
    int c;
    bit fin;
    first_cyc = -1;
    done_cyc  = -1;
    fin       = 1'b0;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.word_cnt  = CW'(cnt);
    drive_ready(rmode, 0);
    tick();
    bus.start = 1'b0;
    c = 1;
    while (!fin && c < LIMIT) begin
      if (first_cyc < 0 && bus.tx_valid) first_cyc = c;
      if (bus.done) done_cyc = c;
      if (!bus.busy) begin
        fin = 1'b1;
      end else begin
        bus.start = (c == inj);
        if (c == inj) begin
          bus.base_addr = 32'h0004_0000;
          bus.word_cnt  = CW'(7);
        end
        drive_ready(rmode, c);
        tick();
        c++;
      end
    end
    bus.start    = 1'b0;
    bus.tx_ready = 1'b1;
    check("run_timeout", 64'(fin), 64'd1);
    tick();
    tick();
  endtask

  typedef struct {
    logic [31:0] base;
    int          cnt;
    int          rmode;     // 0 ready high, 1 toggling, 2 random
    int          inj;       // cycle of an ignored second start, 0 = none
    bit          cmode;     // mux returns DEAD_BEEF outside the fixed entries
    logic [31:0] exp_addr;  // chk_addr after completion
    bit          chkw;      // compare last word against lastw
    logic [31:0] lastw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int first_c, done_c, g0, d0, n;
    logic [31:0] lw, rb;
    int rc;

    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_cnt = '0;
    bus.abort = 1'b0; bus.tx_ready = 1'b0;
    const_mode = 1'b0; const_val = 32'hDEAD_BEEF;

    vecs[0] = '{32'h0001_0000, 2, 0, 0, 1'b0, 32'h0001_0001, 1'b1, 32'h1234_5678};
    vecs[1] = '{32'h00AB_0000, 1, 1, 0, 1'b1, 32'h00AB_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0777, 0, 0, 0, 1'b0, 32'h0000_0777, 1'b0, 32'h0};
    vecs[3] = '{32'hFFFF_FFFF, 2, 0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
    vecs[4] = '{32'h0000_0005, 1, 0, 0, 1'b0, 32'h0000_0005, 1'b0, 32'h0};
    vecs[5] = '{32'h0002_0010, 3, 0, 5, 1'b0, 32'h0002_0012, 1'b0, 32'h0};
    vecs[6] = '{32'h0000_1234, 3, 2, 0, 1'b0, 32'h0000_1236, 1'b0, 32'h0};

    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_done",     64'(bus.done),     64'd0);
    check("rst_chk_addr", 64'(bus.chk_addr), 64'd0);
    check("rst_tx_data",  64'(bus.tx_data),  64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    tick();

    // Table-driven dumps.
    for (int v = 0; v < 7; v++) begin
      const_mode = vecs[v].cmode;
      build_exp(vecs[v].base, vecs[v].cnt);
      g0 = got_q.size();
      d0 = done_cnt;
      run_dump(vecs[v].base, vecs[v].cnt, vecs[v].rmode, vecs[v].inj, first_c, done_c);
      cmp_bytes($sformatf("vec%0d", v), g0);
      check($sformatf("vec%0d_done_pulses", v), 64'(done_cnt - d0), 64'd1);
      check($sformatf("vec%0d_chk_addr", v), 64'(bus.chk_addr), 64'(vecs[v].exp_addr));
      if (vecs[v].rmode == 0) begin
        check($sformatf("vec%0d_done_cycle", v), 64'(done_c), 64'(vecs[v].cnt * T + 1));
        check($sformatf("vec%0d_first_valid", v), 64'(first_c),
              64'((vecs[v].cnt == 0) ? -1 : S + 2));
      end
      if (vecs[v].chkw) begin
        n  = got_q.size();
        lw = {got_q[n-1], got_q[n-2], got_q[n-3], got_q[n-4]};
        check($sformatf("vec%0d_last_word", v), 64'(lw), 64'(vecs[v].lastw));
      end
    end
    const_mode = 1'b0;

    // Abort while byte 1 is stalled.
    build_exp(32'h0000_0100, 3);
    g0 = got_q.size();
    d0 = done_cnt;
    bus.tx_ready = 1'b0;
    bus.start = 1'b1; bus.base_addr = 32'h0000_0100; bus.word_cnt = CW'(3);
    tick();
    bus.start = 1'b0;
    rc = 0;
    while (!bus.tx_valid && rc < 50) begin tick(); rc++; end
    check("abort_first_valid_seen", 64'(bus.tx_valid), 64'd1);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    bus.abort    = 1'b1;
    tick();
    tick();
    check("abort_pending_valid", 64'(bus.tx_valid), 64'd1);
    bus.tx_ready = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy",     64'(bus.busy),     64'd0);
    check("abort_tx_valid", 64'(bus.tx_valid), 64'd0);
    repeat (20) tick();
    check("abort_nbytes", 64'(got_q.size() - g0), 64'd2);
    if (got_q.size() - g0 >= 2) begin
      check("abort_byte0", 64'(got_q[g0]),   64'(exp_q[0]));
      check("abort_byte1", 64'(got_q[g0+1]), 64'(exp_q[1]));
    end
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset while a byte is pending.
    bus.tx_ready = 1'b0;
    bus.start = 1'b1; bus.base_addr = 32'h0000_0300; bus.word_cnt = CW'(2);
    tick();
    bus.start = 1'b0;
    rc = 0;
    while (!bus.tx_valid && rc < 50) begin tick(); rc++; end
    check("rstmid_valid_seen", 64'(bus.tx_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("rstmid_busy",     64'(bus.busy),     64'd0);
    check("rstmid_done",     64'(bus.done),     64'd0);
    check("rstmid_chk_addr", 64'(bus.chk_addr), 64'd0);
    check("rstmid_tx_data",  64'(bus.tx_data),  64'd0);
    check("rstmid_tx_valid", 64'(bus.tx_valid), 64'd0);
    rst = 1'b0;
    tick();
    build_exp(32'h0000_0020, 1);
    g0 = got_q.size();
    d0 = done_cnt;
    run_dump(32'h0000_0020, 1, 0, 0, first_c, done_c);
    cmp_bytes("after_rst", g0);
    check("after_rst_done", 64'(done_cnt - d0), 64'd1);
    check("after_rst_done_cycle", 64'(done_c), 64'(T + 1));

    // Random dumps with random backpressure.
    for (int r = 0; r < 8; r++) begin
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      n  = $urandom_range(0, 4);
      build_exp(rb, n);
      g0 = got_q.size();
      d0 = done_cnt;
      run_dump(rb, n, 2, 0, first_c, done_c);
      cmp_bytes($sformatf("rnd%0d", r), g0);
      check($sformatf("rnd%0d_done", r), 64'(done_cnt - d0), 64'd1);
      check($sformatf("rnd%0d_chk_addr", r), 64'(bus.chk_addr),
            64'((n == 0) ? rb : rb + 32'(n - 1)));
    end

    check("tx_stable_under_stall", 64'(stab_viol), 64'd0);
    check("busy_low_with_done",    64'(busy_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
